// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: memory-port handshakes, EX stall/branch inputs and the
// stall/flush/redirect outputs. slave = controller side, master = pipeline side.
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic              if_done;
    logic              mem_req;
    logic              mem_done;
    logic              ex_stall_req;
    logic              ex_branch_taken;
    logic [ADDR_W-1:0] ex_branch_target;

    logic              if_grant;
    logic              mem_grant;
    logic [1:0]        halt_type;
    logic              ifid_discard;
    logic              idex_discard;
    logic              pc_redirect;
    logic [ADDR_W-1:0] pc_redirect_addr;
    logic              flush_pending;

    modport slave (
        input  if_req, if_done, mem_req, mem_done,
        input  ex_stall_req, ex_branch_taken, ex_branch_target,
        output if_grant, mem_grant, halt_type,
        output ifid_discard, idex_discard, pc_redirect, pc_redirect_addr,
        output flush_pending
    );

    modport master (
        output if_req, if_done, mem_req, mem_done,
        output ex_stall_req, ex_branch_taken, ex_branch_target,
        input  if_grant, mem_grant, halt_type,
        input  ifid_discard, idex_discard, pc_redirect, pc_redirect_addr,
        input  flush_pending
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: IF/MEM memory-port arbiter, halt_type stall code,
// branch redirects and flushes (including deferred flush of an in-flight fetch).
module pipe_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_OWN  = 2'd1,
        MEM_OWN = 2'd2
    } state_t;

    state_t            state_reg;
    logic              if_grant_reg;
    logic              mem_grant_reg;
    logic              flush_pending_reg;

    logic              mem_hold;
    logic              if_hold;
    logic [1:0]        halt_code;
    logic              accept;
    logic              late_discard;
    logic [ADDR_W-1:0] redirect_addr_next;

    // A transaction stops holding the pipeline in the very cycle its done pulse arrives.
    always_comb begin
        mem_hold  = bus.mem_req && !(state_reg == MEM_OWN && bus.mem_done);
        if_hold   = bus.if_req  && !(state_reg == IF_OWN  && bus.if_done);
        halt_code = 2'b00;
        if (rst)
            halt_code = 2'b00;
        else if (mem_hold)
            halt_code = 2'b11;
        else if (bus.ex_stall_req)
            halt_code = 2'b10;
        else if (if_hold)
            halt_code = 2'b01;
        accept             = !rst && bus.ex_branch_taken && !halt_code[1];
        late_discard       = !rst && flush_pending_reg && bus.if_done;
        redirect_addr_next = accept ? bus.ex_branch_target : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            if_grant_reg      <= 1'b0;
            mem_grant_reg     <= 1'b0;
            flush_pending_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.mem_req) begin
                        state_reg     <= MEM_OWN;
                        mem_grant_reg <= 1'b1;
                    end else if (bus.if_req) begin
                        state_reg    <= IF_OWN;
                        if_grant_reg <= 1'b1;
                    end
                end
                IF_OWN: begin
                    // A fetch is never aborted; a waiting MEM request takes over directly.
                    if (bus.if_done) begin
                        if_grant_reg <= 1'b0;
                        if (bus.mem_req) begin
                            state_reg     <= MEM_OWN;
                            mem_grant_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                MEM_OWN: begin
                    if (bus.mem_done) begin
                        state_reg     <= IDLE;
                        mem_grant_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    if_grant_reg  <= 1'b0;
                    mem_grant_reg <= 1'b0;
                end
            endcase

            // Branch taken while the fetch is still outstanding: its data is wrong-path.
            if (accept && state_reg == IF_OWN && !bus.if_done)
                flush_pending_reg <= 1'b1;
            else if (flush_pending_reg && bus.if_done)
                flush_pending_reg <= 1'b0;
        end
    end

    assign bus.if_grant         = if_grant_reg && !rst;
    assign bus.mem_grant        = mem_grant_reg && !rst;
    assign bus.halt_type        = halt_code;
    assign bus.pc_redirect      = accept;
    assign bus.pc_redirect_addr = redirect_addr_next;
    assign bus.idex_discard     = accept;
    assign bus.ifid_discard     = accept || late_discard;
    assign bus.flush_pending    = flush_pending_reg && !rst;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed test-plan steps followed by randomized traffic,
// all checked against an ownership/pending-flush reference model.
module tb_pipe_ctrl;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    pipe_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the memory port (0 none, 1 fetch, 2 MEM) and
    // whether a wrong-path fetch result still has to be dropped.
    int         m_owner = 0;
    bit         m_pend  = 1'b0;
    logic [1:0] e_halt;
    bit         e_acc   = 1'b0;
    int         n_redir;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        if (rst)
            e_halt = 2'd0;
        else if (bus.mem_req && !(m_owner == 2 && bus.mem_done))
            e_halt = 2'd3;
        else if (bus.ex_stall_req)
            e_halt = 2'd2;
        else if (bus.if_req && !(m_owner == 1 && bus.if_done))
            e_halt = 2'd1;
        else
            e_halt = 2'd0;
        e_acc = !rst && bus.ex_branch_taken && (e_halt < 2);
        $display("cyc t=%0t rst=%0b ifr=%0b ifd=%0b mr=%0b md=%0b st=%0b br=%0b owner=%0d halt=%0d acc=%0b",
                 $time, rst, bus.if_req, bus.if_done, bus.mem_req, bus.mem_done,
                 bus.ex_stall_req, bus.ex_branch_taken, m_owner, e_halt, e_acc);
        chk("if_grant",      bus.if_grant,  !rst && m_owner == 1);
        chk("mem_grant",     bus.mem_grant, !rst && m_owner == 2);
        chk("halt_type",     bus.halt_type, e_halt);
        chk("ifid_discard",  bus.ifid_discard, e_acc || (!rst && m_pend && bus.if_done));
        chk("idex_discard",  bus.idex_discard, e_acc);
        chk("pc_redirect",   bus.pc_redirect, e_acc);
        chk("redirect_addr", bus.pc_redirect_addr, e_acc ? bus.ex_branch_target : 32'd0);
        chk("flush_pending", bus.flush_pending, !rst && m_pend);
    endtask

    task automatic adv();
        if (rst) begin
            m_owner = 0;
            m_pend  = 1'b0;
        end else begin
            if (e_acc && m_owner == 1 && !bus.if_done)
                m_pend = 1'b1;
            else if (m_pend && bus.if_done)
                m_pend = 1'b0;
            case (m_owner)
                0:       m_owner = bus.mem_req ? 2 : (bus.if_req ? 1 : 0);
                1:       if (bus.if_done) m_owner = bus.mem_req ? 2 : 0;
                default: if (bus.mem_done) m_owner = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b1;  bus.if_done = 1'b0;
        bus.mem_req = 1'b1; bus.mem_done = 1'b0;
        bus.ex_stall_req = 1'b0; bus.ex_branch_taken = 1'b0;
        bus.ex_branch_target = 32'd0;

        // Reset with both requests up: everything quiet.
        settle(); chk("rst_halt", bus.halt_type, 2'b00); adv();
        settle(); adv();
        rst = 1'b0;
        settle(); chk("post_rst_mem_grant0", bus.mem_grant, 1'b0); chk("post_rst_halt", bus.halt_type, 2'b11); adv();
        settle(); chk("post_rst_mem_grant1", bus.mem_grant, 1'b1); adv();
        bus.mem_done = 1'b1;
        settle(); adv();
        bus.mem_done = 1'b0; bus.mem_req = 1'b0;
        settle(); adv();

        // Fetch with 3-cycle occupancy.
        for (int i = 0; i < 3; i++) begin
            bus.if_done = (i == 2);
            settle();
            chk("t2_if_grant", bus.if_grant, 1'b1);
            chk("t2_halt", bus.halt_type, (i == 2) ? 2'b00 : 2'b01);
            adv();
        end
        bus.if_done = 1'b0; bus.if_req = 1'b0;
        settle(); chk("t2_idle_grant", bus.if_grant, 1'b0); adv();

        // MEM request arriving during a fetch.
        bus.if_req = 1'b1;
        settle(); adv();
        bus.mem_req = 1'b1;
        settle(); chk("t3_halt_imm", bus.halt_type, 2'b11); adv();
        bus.if_done = 1'b1;
        settle(); chk("t3_halt_done", bus.halt_type, 2'b11); adv();
        bus.if_done = 1'b0; bus.if_req = 1'b0;
        settle(); chk("t3_mem_own", bus.mem_grant, 1'b1); adv();
        bus.mem_done = 1'b1;
        settle(); chk("t3_release", bus.halt_type, 2'b00); adv();
        bus.mem_done = 1'b0; bus.mem_req = 1'b0;
        settle(); chk("t3_idle", bus.mem_grant, 1'b0); adv();

        // Branch with nothing in flight.
        bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h0000_1000;
        settle();
        chk("t4_redirect", bus.pc_redirect, 1'b1);
        chk("t4_addr", bus.pc_redirect_addr, 32'h0000_1000);
        chk("t4_ifid", bus.ifid_discard, 1'b1);
        chk("t4_idex", bus.idex_discard, 1'b1);
        adv();
        bus.ex_branch_taken = 1'b0;
        settle(); chk("t4_after", bus.pc_redirect, 1'b0); adv();

        // Branch during an outstanding fetch.
        bus.if_req = 1'b1;
        settle(); adv();
        bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h0000_2040;
        settle(); chk("t5_redirect", bus.pc_redirect, 1'b1); adv();
        bus.ex_branch_taken = 1'b0;
        settle(); chk("t5_pending", bus.flush_pending, 1'b1); adv();
        bus.if_done = 1'b1;
        settle(); chk("t5_late_discard", bus.ifid_discard, 1'b1); adv();
        bus.if_done = 1'b0; bus.if_req = 1'b0;
        settle(); chk("t5_cleared", bus.flush_pending, 1'b0); adv();

        // Branch held through a MEM stall: exactly one redirect, on the done cycle.
        n_redir = 0;
        bus.mem_req = 1'b1; bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h0000_3000;
        for (int i = 0; i < 4; i++) begin
            bus.mem_done = (i == 3);
            settle();
            if (bus.pc_redirect) n_redir++;
            chk("t6_redirect_cycle", bus.pc_redirect, (i == 3));
            adv();
        end
        bus.mem_done = 1'b0; bus.mem_req = 1'b0; bus.ex_branch_taken = 1'b0;
        settle();
        if (bus.pc_redirect) n_redir++;
        chk("t6_redirect_count", n_redir, 1);
        adv();

        // Randomized traffic obeying the request/done handshake.
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (bus.if_done)      bus.if_req = $urandom_range(0, 1);
            else if (!bus.if_req) bus.if_req = ($urandom_range(0, 3) == 0);
            if (bus.mem_done)      bus.mem_req = $urandom_range(0, 1);
            else if (!bus.mem_req) bus.mem_req = ($urandom_range(0, 4) == 0);
            bus.if_done  = !rst && (m_owner == 1) && ($urandom_range(0, 2) == 0);
            bus.mem_done = !rst && (m_owner == 2) && ($urandom_range(0, 2) == 0);
            bus.ex_stall_req = ($urandom_range(0, 4) == 0);
            if (!(bus.ex_branch_taken && !e_acc)) begin
                bus.ex_branch_taken  = ($urandom_range(0, 5) == 0);
                bus.ex_branch_target = $urandom;
            end
            settle();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
